alu_share_ctrl: RTL

Two-requester arbiter and sequencer for the shared WIDTH-bit ALU in the execute datapath. It accepts operations from two independent requesters over valid/ready handshakes and registers the winner's operands. It drives one ALU instance, returns the registered result and NZCV flags on a shared response bus, and keeps a separate flag register per requester. Each requester's stored C flag feeds the ALU carry-in for that requester's carry-using operations.

---
 rtl/alu_share_if.sv | 55 +++++
 rtl/alu_share_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_if.sv
// -----------------------------------------------------------------------------
// alu_share_if
// Bundle of the two requester handshakes, the shared response bus and the
// per-requester flag/status outputs of alu_share_ctrl.
//
// Ports (per requester X = 0/1):
//   reqX_valid     master->slave  operation pending
//   reqX_ready     slave->master  operation accepted this cycle
//   reqX_control   master->slave  4-bit ALU opcode
//   reqX_a/b       master->slave  WIDTH-bit operands
//   reqX_setflags  master->slave  update requester X flag register
// Shared:
//   rsp_valid/rsp_id/rsp_data/rsp_flags  slave->master  registered result
//   flags0/flags1                        slave->master  stored {N,Z,C,V}
//   busy                                 slave->master  controller executing
// -----------------------------------------------------------------------------
interface alu_share_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_control;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_setflags;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_control;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_setflags;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic [3:0]       rsp_flags;
  logic [3:0]       flags0;
  logic [3:0]       flags1;
  logic             busy;

  modport master (
    output req0_valid, req0_control, req0_a, req0_b, req0_setflags,
    output req1_valid, req1_control, req1_a, req1_b, req1_setflags,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_flags, flags0, flags1, busy
  );

  modport slave (
    input  req0_valid, req0_control, req0_a, req0_b, req0_setflags,
    input  req1_valid, req1_control, req1_a, req1_b, req1_setflags,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_flags, flags0, flags1, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
// Arbiter/sequencer for one shared WIDTH-bit ALU serving two requesters.
// A granted operation is latched into operand registers (IDLE edge), executed
// from those registers for one cycle (EXEC), and its result/flags are
// registered onto the shared response bus together with the issuer's flag
// register update. One operation every two cycles.
//
// Ports:
//   clk    single rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_share_if.slave: two request handshakes, response bus,
//          stored flags0/flags1 and busy
//
// Build option:
//   ALU_SHARE_RR_EN  defined   -> round-robin arbitration (last_grant kept)
//                    undefined -> fixed priority, requester 0 always wins
//
// Opcodes: 0000 AND, 0001 EOR, 0010 SUB, 0011 RSB, 0100 ADD, 0101 ADC,
//          0110 SBC, 0111 RSC, 1100 ORR, 1101 MOV, 1110 BIC, 1111 MVN,
//          1000-1011 undefined (result 0, flags 0100).
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  alu_share_if.slave bus
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t state_reg, state_next;
  logic   grant0, grant1, busy;

  logic [3:0]       op_ctrl_reg;
  logic [WIDTH-1:0] op_a_reg, op_b_reg;
  logic             op_setflags_reg, op_id_reg, op_cin_reg;

  logic             rsp_valid_reg, rsp_id_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic [3:0]       rsp_flags_reg;

  logic [3:0] flags_cur [2];

`ifdef ALU_SHARE_RR_EN
  logic last_grant_reg;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next state, arbitration and handshake outputs. Ready is also gated by
  // rst_n so nothing reads as accepted while reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    grant0     = 1'b0;
    grant1     = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rst_n) begin
`ifdef ALU_SHARE_RR_EN
          if (bus.req0_valid && bus.req1_valid) begin
            // last_grant = 1 means requester 1 was served last
            grant0 = last_grant_reg;
            grant1 = ~last_grant_reg;
          end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
          end
`else
          grant0 = bus.req0_valid;
          grant1 = bus.req1_valid & ~bus.req0_valid;
`endif
        end
        if (grant0 || grant1) state_next = EXEC;
      end
      EXEC: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ALU_SHARE_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 last_grant_reg <= 1'b1;
    else if (grant0 || grant1)  last_grant_reg <= grant1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Operand capture on grant; carry-in is the winner's stored C at that edge,
  // which already includes the update from the previous response.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_ctrl_reg     <= '0;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      op_setflags_reg <= 1'b0;
      op_id_reg       <= 1'b0;
      op_cin_reg      <= 1'b0;
    end else if (grant0 || grant1) begin
      op_ctrl_reg     <= grant1 ? bus.req1_control  : bus.req0_control;
      op_a_reg        <= grant1 ? bus.req1_a        : bus.req0_a;
      op_b_reg        <= grant1 ? bus.req1_b        : bus.req0_b;
      op_setflags_reg <= grant1 ? bus.req1_setflags : bus.req0_setflags;
      op_id_reg       <= grant1;
      op_cin_reg      <= grant1 ? flags_cur[1][1]   : flags_cur[0][1];
    end
  end

  // ---------------------------------------------------------------------------
  // Shared ALU, fed only from the operand registers. Subtractions use
  // x + ~y + cin so carry-out is the ARM-style "no borrow" flag.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_x, alu_y, alu_res;
  logic [WIDTH:0]   alu_sum;
  logic             alu_ci, alu_arith, alu_n, alu_z, alu_c, alu_v;

  always_comb begin
    alu_x     = '0;
    alu_y     = '0;
    alu_ci    = 1'b0;
    alu_arith = 1'b0;
    alu_res   = '0;
    case (op_ctrl_reg)
      4'b0000: alu_res = op_a_reg & op_b_reg;
      4'b0001: alu_res = op_a_reg ^ op_b_reg;
      4'b0010: begin alu_arith = 1'b1; alu_x = op_a_reg; alu_y = ~op_b_reg; alu_ci = 1'b1;       end
      4'b0011: begin alu_arith = 1'b1; alu_x = op_b_reg; alu_y = ~op_a_reg; alu_ci = 1'b1;       end
      4'b0100: begin alu_arith = 1'b1; alu_x = op_a_reg; alu_y = op_b_reg;  alu_ci = 1'b0;       end
      4'b0101: begin alu_arith = 1'b1; alu_x = op_a_reg; alu_y = op_b_reg;  alu_ci = op_cin_reg; end
      4'b0110: begin alu_arith = 1'b1; alu_x = op_a_reg; alu_y = ~op_b_reg; alu_ci = op_cin_reg; end
      4'b0111: begin alu_arith = 1'b1; alu_x = op_b_reg; alu_y = ~op_a_reg; alu_ci = op_cin_reg; end
      4'b1100: alu_res = op_a_reg | op_b_reg;
      4'b1101: alu_res = op_b_reg;
      4'b1110: alu_res = op_a_reg & ~op_b_reg;
      4'b1111: alu_res = ~op_b_reg;
      default: alu_res = '0;   // undefined opcodes give 0 -> flags 0100
    endcase
    alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + {{WIDTH{1'b0}}, alu_ci};
    if (alu_arith) alu_res = alu_sum[WIDTH-1:0];
    alu_n = alu_res[WIDTH-1];
    alu_z = (alu_res == '0);
    alu_c = alu_arith & alu_sum[WIDTH];
    alu_v = alu_arith & (alu_x[WIDTH-1] == alu_y[WIDTH-1]) &
            (alu_res[WIDTH-1] != alu_x[WIDTH-1]);
  end

  // ---------------------------------------------------------------------------
  // Response registers: loaded on the EXEC edge, rsp_valid is a 1-cycle pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_flags_reg <= '0;
    end else if (state_reg == EXEC) begin
      rsp_valid_reg <= 1'b1;
      rsp_id_reg    <= op_id_reg;
      rsp_data_reg  <= alu_res;
      rsp_flags_reg <= {alu_n, alu_z, alu_c, alu_v};
    end else begin
      rsp_valid_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-requester flag registers. Non-arithmetic results keep the old C and V.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_flags
      logic [3:0] flags_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          flags_reg <= '0;
        end else if (state_reg == EXEC && op_setflags_reg && op_id_reg == 1'(gi)) begin
          flags_reg <= alu_arith ? {alu_n, alu_z, alu_c, alu_v}
                                 : {alu_n, alu_z, flags_reg[1:0]};
        end
      end
      assign flags_cur[gi] = flags_reg;
    end
  endgenerate

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.busy       = busy;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_id     = rsp_id_reg;
  assign bus.rsp_data   = rsp_data_reg;
  assign bus.rsp_flags  = rsp_flags_reg;
  assign bus.flags0     = flags_cur[0];
  assign bus.flags1     = flags_cur[1];

endmodule
